// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud generator and its configuration path.
package uart_pkg;

    localparam int unsigned DIV_W = 32;

    typedef enum logic [1:0] {
        BCTL_IDLE = 2'd0,
        BCTL_PEND = 2'd1,
        BCTL_SYNC = 2'd2
    } bctl_state_e;

    // Truncating divisor giving `oversample` baud_clk ticks per bit at `baud_rate`.
    function automatic logic [DIV_W-1:0] calc_default_div(
        input int unsigned clk_freq,
        input int unsigned baud_rate,
        input int unsigned oversample
    );
        return DIV_W'(clk_freq / (baud_rate * oversample));
    endfunction

endpackage

// File: rtl/uart_baud_ctrl_chk.sv
// Invariants on the baud controller's output pulses.
module uart_baud_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic cfg_ack,
    input logic div_load,
    input logic busy,
    input logic bit_tick
);

    ack_is_load:   assert property (@(posedge clk) disable iff (rst) cfg_ack == div_load);
    ack_ends_busy: assert property (@(posedge clk) disable iff (rst) cfg_ack |-> !busy);
    ack_is_pulse:  assert property (@(posedge clk) disable iff (rst) cfg_ack |=> !cfg_ack);
    tick_is_pulse: assert property (@(posedge clk) disable iff (rst) bit_tick |=> !bit_tick);

endmodule

// File: rtl/uart_tick_div.sv
// Divides the oversample tick into a bit-rate strobe; a synchronous clear realigns the bit phase.
module uart_tick_div #(
    parameter int unsigned oversample = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clr,
    output logic bit_tick
);

    localparam int unsigned     PH_W    = (oversample > 1) ? $clog2(oversample) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(oversample - 32'd1);

    logic [PH_W-1:0] phase_r;
    logic [PH_W-1:0] phase_nxt_s;
    logic            bit_tick_r;
    logic            bit_tick_nxt_s;

    // Next phase and strobe; a clear outranks a coincident tick, which is then neither counted nor strobed.
    always_comb begin
        phase_nxt_s    = phase_r;
        bit_tick_nxt_s = 1'b0;
        if (clr) begin
            phase_nxt_s = {PH_W{1'b0}};
        end else if (tick) begin
            if (phase_r == PH_LAST) begin
                phase_nxt_s    = {PH_W{1'b0}};
                bit_tick_nxt_s = 1'b1;
            end else begin
                phase_nxt_s = phase_r + PH_W'(1'b1);
            end
        end else begin
            phase_nxt_s = phase_r;
        end
    end

    // Phase and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r    <= {PH_W{1'b0}};
            bit_tick_r <= 1'b0;
        end else begin
            phase_r    <= phase_nxt_s;
            bit_tick_r <= bit_tick_nxt_s;
        end
    end

    assign bit_tick = bit_tick_r;

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud divisor configuration controller: validates divisor writes, defers them until the
// datapaths are idle, applies them on a baud_clk tick and keeps the bit phase aligned.
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq    = 100_000_000,
    parameter int unsigned baud_rate   = 9600,
    parameter int unsigned oversample  = 16,
    parameter int unsigned min_div     = 2,
    parameter int unsigned timeout_cyc = 1_000_000,
    parameter int unsigned default_div = calc_default_div(clk_freq, baud_rate, oversample)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             busy,
    input  logic             tx_busy,
    input  logic             rx_busy,
    input  logic             baud_clk,
    output logic [DIV_W-1:0] div_out,
    output logic             div_load,
    output logic             bit_tick
);

    localparam int unsigned      TO_W    = (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(timeout_cyc - 32'd1);
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(min_div);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(default_div);

    bctl_state_e      state_r;
    bctl_state_e      state_nxt_s;
    logic [DIV_W-1:0] shadow_r;
    logic [DIV_W-1:0] shadow_nxt_s;
    logic [TO_W-1:0]  to_cnt_r;
    logic [TO_W-1:0]  to_cnt_nxt_s;
    logic [DIV_W-1:0] div_out_r;
    logic [DIV_W-1:0] div_out_nxt_s;
    logic             reject_s;
    logic             abort_s;
    logic             apply_s;
    logic             cfg_ack_r;
    logic             cfg_err_r;
    logic             busy_r;
    logic             div_load_r;

    // Update sequencing; any write arriving while an update is pending is refused without disturbing it.
    always_comb begin
        state_nxt_s   = state_r;
        shadow_nxt_s  = shadow_r;
        to_cnt_nxt_s  = to_cnt_r;
        div_out_nxt_s = div_out_r;
        reject_s      = 1'b0;
        abort_s       = 1'b0;
        apply_s       = 1'b0;
        case (state_r)
            BCTL_IDLE: begin
                if (cfg_wr) begin
                    if (cfg_div < MIN_DIV) begin
                        reject_s = 1'b1;
                    end else begin
                        shadow_nxt_s = cfg_div;
                        to_cnt_nxt_s = {TO_W{1'b0}};
                        state_nxt_s  = BCTL_PEND;
                    end
                end else begin
                    state_nxt_s = BCTL_IDLE;
                end
            end
            BCTL_PEND: begin
                reject_s = cfg_wr;
                if (!tx_busy && !rx_busy) begin
                    state_nxt_s = BCTL_SYNC;
                end else if (to_cnt_r == TO_LAST) begin
                    abort_s      = 1'b1;
                    shadow_nxt_s = {DIV_W{1'b0}};
                    state_nxt_s  = BCTL_IDLE;
                end else begin
                    to_cnt_nxt_s = to_cnt_r + TO_W'(1'b1);
                end
            end
            BCTL_SYNC: begin
                // A frame starting before the tick sends us back to waiting; the timeout keeps running.
                reject_s = cfg_wr;
                if (tx_busy || rx_busy) begin
                    state_nxt_s = BCTL_PEND;
                end else if (baud_clk) begin
                    apply_s       = 1'b1;
                    div_out_nxt_s = shadow_r;
                    state_nxt_s   = BCTL_IDLE;
                end else begin
                    state_nxt_s = BCTL_SYNC;
                end
            end
            default: begin
                state_nxt_s  = BCTL_IDLE;
                shadow_nxt_s = {DIV_W{1'b0}};
                to_cnt_nxt_s = {TO_W{1'b0}};
            end
        endcase
    end

    // State, shadow and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= BCTL_IDLE;
            shadow_r   <= {DIV_W{1'b0}};
            to_cnt_r   <= {TO_W{1'b0}};
            div_out_r  <= DEF_DIV;
            cfg_ack_r  <= 1'b0;
            cfg_err_r  <= 1'b0;
            busy_r     <= 1'b0;
            div_load_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shadow_r   <= shadow_nxt_s;
            to_cnt_r   <= to_cnt_nxt_s;
            div_out_r  <= div_out_nxt_s;
            cfg_ack_r  <= apply_s;
            cfg_err_r  <= reject_s | abort_s;
            busy_r     <= (state_nxt_s != BCTL_IDLE);
            div_load_r <= apply_s;
        end
    end

    uart_tick_div #(
        .oversample (oversample)
    ) u_tick_div (
        .clk      (clk),
        .rst      (rst),
        .tick     (baud_clk),
        .clr      (apply_s),
        .bit_tick (bit_tick)
    );

    uart_baud_ctrl_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .cfg_ack  (cfg_ack_r),
        .div_load (div_load_r),
        .busy     (busy_r),
        .bit_tick (bit_tick)
    );

    assign cfg_ack  = cfg_ack_r;
    assign cfg_err  = cfg_err_r;
    assign busy     = busy_r;
    assign div_out  = div_out_r;
    assign div_load = div_load_r;

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Configuration controller for the UART baud generator. Accepts divisor updates from the APB register block, checks them, and holds each one until the TX and RX datapaths are idle. It then loads the divisor into `baud_gen` on a tick boundary. It also divides the oversampled `baud_clk` tick into a bit-rate strobe for the TX/RX sequencers, keeping the bit phase coherent across divisor changes.

## Interface
Parameters:
- `clk_freq`, 100_000_000: system clock frequency in Hz.
- `baud_rate`, 9600: power-on baud rate.
- `oversample`, 16: `baud_clk` ticks per bit. Must be at least 2.
- `min_div`, 2: smallest legal divisor.
- `timeout_cyc`, 1_000_000: maximum number of cycles spent waiting for idle.
- `default_div`, derived as `clk_freq/(baud_rate*oversample)`. The integer division truncates, giving 651 with the defaults.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_wr`  in  1  one-cycle divisor write strobe from the register block.
- `cfg_div`  in  32  requested divisor, sampled when `cfg_wr` is high.
- `cfg_ack`  out  1  one-cycle pulse: the divisor has been applied.
- `cfg_err`  out  1  one-cycle pulse: the write was rejected, or the update was aborted.
- `busy`  out  1  high while an update is pending.
- `tx_busy`  in  1  TX frame in progress.
- `rx_busy`  in  1  RX frame in progress.
- `baud_clk`  in  1  oversample tick from `baud_gen`.
- `div_out`  out  32  divisor driven to `baud_gen` `div_in`.
- `div_load`  out  1  one-cycle pulse marking a new `div_out`. The top level uses it to restart the `baud_gen` counter.
- `bit_tick`  out  1  one pulse per `oversample` `baud_clk` ticks.

## Operation
The FSM has three states: IDLE, PEND and SYNC.

IDLE:
- `cfg_wr` with `cfg_div < min_div`: pulse `cfg_err`; stay in IDLE.
- `cfg_wr` with a legal divisor: latch it into the shadow register, clear the timeout counter, go to PEND.

PEND:
- `tx_busy` = 0 and `rx_busy` = 0 in the same cycle: go to SYNC.
- Otherwise increment the timeout counter.
- Counter reaches `timeout_cyc`-1: pulse `cfg_err`, discard the shadow, go to IDLE. `div_out` is unchanged.

SYNC:
- Wait for `baud_clk`=1. On that cycle:
  - set `div_out` to the shadow value;
  - pulse `div_load` and `cfg_ack`;
  - clear the phase counter;
  - go to IDLE.
- If `tx_busy` or `rx_busy` rises while in SYNC, return to PEND. The timeout counter is not cleared.

Rules that apply in every state:
- `cfg_wr` while `busy` is high: pulse `cfg_err` and drop the request. The update already in progress is unaffected.
- Phase counter:
  - width is `$clog2(oversample)`; it counts `baud_clk` pulses from 0 to `oversample`-1 and wraps to 0;
  - `bit_tick` pulses on a `baud_clk` pulse that arrives while the phase is `oversample`-1;
  - the apply-cycle clear takes priority over a count, so the tick consumed by the apply neither counts nor produces `bit_tick`.
- The divisor compare is unsigned 32-bit. 0 is illegal under the default parameters.

Reset:
- `rst` clears everything, including mid-update: the state returns to IDLE, the shadow is discarded, and no `cfg_ack` or `cfg_err` is produced.

## Timing
- All outputs are registered.
- Reset values:
  - `div_out` = `default_div`;
  - `cfg_ack`, `cfg_err`, `busy`, `div_load`, `bit_tick` = 0;
  - phase counter = 0.
- Rejected write with `cfg_wr` at cycle N: `cfg_err`=1 in cycle N+1 only.
- Accepted write with `cfg_wr` at cycle N: `busy`=1 from N+1.
  - If both busy inputs are low at N+1, the FSM is in SYNC at N+2.
  - A `baud_clk` pulse at cycle M (M ≥ N+2) makes `div_out`, `div_load` and `cfg_ack` valid in cycle M+1; `busy`=0 from M+1.
  - Minimum latency from `cfg_wr` to `cfg_ack` is 3 cycles.
- `bit_tick` appears 1 cycle after the qualifying `baud_clk` pulse.
- After a `div_load`, the first `bit_tick` follows the `oversample`-th subsequent `baud_clk` pulse.

## Structure
- Put these in the shared package `uart_pkg`:
  - the state enum (`BCTL_IDLE`, `BCTL_PEND`, `BCTL_SYNC`);
  - the `default_div` constant function;
  - the 32-bit divisor width constant.
- Use one sub-module, `uart_tick_div`: the phase counter with a synchronous clear input and `bit_tick` generation. `uart_baud_ctrl` instantiates it, and the TX/RX sequencers can reuse it.

## Test plan
- Reset, then 64 `baud_clk` pulses with no writes → `div_out`=651, `bit_tick` exactly 4 times, `cfg_ack`/`cfg_err` never high.
- `cfg_wr` with `cfg_div`=0, both busy inputs low → `cfg_err` for 1 cycle at N+1; `div_out` stays 651; `busy` stays 0.
- `cfg_wr` with `cfg_div`=54, both busy inputs low, `baud_clk` at N+5 → `div_out`=54, `div_load`=1 and `cfg_ack`=1 in N+6 only; the next `bit_tick` comes after 16 further ticks.
- `cfg_wr` with `cfg_div`=54 while `tx_busy`=1 for 500 cycles → `busy` held for those cycles; the apply happens only after `tx_busy` falls and a subsequent tick arrives. A second `cfg_wr` during the wait → `cfg_err`, and 54 is still applied.
- `timeout_cyc`=100, `rx_busy` stuck high → `cfg_err` 100 cycles after PEND entry; `div_out` unchanged; FSM back in IDLE.
- `rst` asserted while in SYNC → the next cycle shows the reset values; no `cfg_ack`; `div_out`=651.
